// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: execute-stage multiply/divide unit with architectural HI/LO.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous active-low reset, clears HI/LO, busy, counter and shadow
//   start  - op valid this cycle
//   op     - 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-10 MADD/MADDU/MSUB/MSUBU
//   a, b   - forwarded rs / rt values
//   cancel - abort the in-flight operation, also blocks acceptance while idle
//   busy   - registered, high while a multi-cycle operation is in flight
//   hi, lo - architectural HI and LO
// Build option: define MULDIV_MADD_EN to enable the accumulate ops 7-10.
module ex_muldiv_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {C_SET, C_ADD, C_SUB, C_NONE} commit_t;
    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);
    logic [3:0]  cnt;
    logic [63:0] shadow;
    commit_t     mode;
    logic        is_mul, is_div, mul_signed, div_signed;
    logic [63:0] prod, res;
    logic [31:0] dividend, divisor, quo, rem;
    commit_t     acc_mode, mode_nxt;
    always_comb begin
`ifdef MULDIV_MADD_EN
        is_mul     = op == 4'd1 || op == 4'd2 || (op >= 4'd7 && op <= 4'd10);
        mul_signed = op == 4'd1 || op == 4'd7 || op == 4'd9;
        acc_mode   = (op == 4'd7 || op == 4'd8) ? C_ADD : (op == 4'd9 || op == 4'd10) ? C_SUB : C_SET;
`else
        is_mul     = op == 4'd1 || op == 4'd2;
        mul_signed = op == 4'd1;
        acc_mode   = C_SET;
`endif
        is_div     = op == 4'd3 || op == 4'd4;
        div_signed = op == 4'd3;
        // Low 64 bits of the product of sign/zero-extended operands equal the 32x32 product.
        prod       = mul_signed ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'd0, a} * {32'd0, b};
        // Signed division on magnitudes, then re-apply signs: truncation toward zero,
        // remainder follows the dividend; 0x80000000/-1 wraps to 0x80000000 naturally.
        dividend   = (div_signed && a[31]) ? -a : a;
        divisor    = (div_signed && b[31]) ? -b : b;
        quo        = dividend / (divisor == 32'd0 ? 32'd1 : divisor);
        rem        = dividend % (divisor == 32'd0 ? 32'd1 : divisor);
        res        = is_div ? {((div_signed && a[31]) ? -rem : rem), ((div_signed && (a[31] ^ b[31])) ? -quo : quo)} : prod;
        // Divide by zero still runs the full latency but never commits.
        mode_nxt   = (is_div && b == 32'd0) ? C_NONE : acc_mode;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            shadow <= '0;
            mode   <= C_SET;
            hi     <= '0;
            lo     <= '0;
        end else if (busy) begin
            if (cancel) begin
                busy   <= 1'b0;
                cnt    <= '0;
                shadow <= '0;
            end else if (cnt == 4'd0) begin
                busy <= 1'b0;
                if (mode != C_NONE)
                    {hi, lo} <= mode == C_ADD ? {hi, lo} + shadow : mode == C_SUB ? {hi, lo} - shadow : shadow;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (start && !cancel) begin
            if (op == 4'd5) begin
                hi <= a;
            end else if (op == 4'd6) begin
                lo <= a;
            end else if (is_mul || is_div) begin
                busy   <= 1'b1;
                cnt    <= is_mul ? MULT_CNT : DIV_CNT;
                shadow <= res;
                mode   <= mode_nxt;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random checks of ex_muldiv_unit against an arithmetic model.
module tb_ex_muldiv_unit;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy;
    logic [31:0] hi, lo;
    logic [31:0] mhi = 32'd0, mlo = 32'd0;
    int          errors = 0, checks = 0;
    ex_muldiv_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Architectural effect of one accepted op on the model {hi,lo}.
    function automatic void predict(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [63:0] nxt, output bit lng, output int lat);
        int sx = x;
        int sy = y;
        longint sp = longint'(sx) * longint'(sy);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint unsigned up = ux * uy;
        nxt = {mhi, mlo};
        lng = 1'b0;
        lat = 0;
        case (o)
            4'd1: begin nxt = sp; lng = 1'b1; lat = MULT_LAT; end
            4'd2: begin nxt = up; lng = 1'b1; lat = MULT_LAT; end
            4'd3: begin
                lng = 1'b1; lat = DIV_LAT;
                if (y != 0)
                    nxt = (x == 32'h80000000 && y == 32'hFFFFFFFF) ? {32'd0, 32'h80000000}
                                                                  : {32'(sx % sy), 32'(sx / sy)};
            end
            4'd4: begin lng = 1'b1; lat = DIV_LAT; if (y != 0) nxt = {x % y, x / y}; end
            4'd5: nxt[63:32] = x;
            4'd6: nxt[31:0] = x;
`ifdef MULDIV_MADD_EN
            4'd7:  begin nxt = {mhi, mlo} + sp; lng = 1'b1; lat = MULT_LAT; end
            4'd8:  begin nxt = {mhi, mlo} + up; lng = 1'b1; lat = MULT_LAT; end
            4'd9:  begin nxt = {mhi, mlo} - sp; lng = 1'b1; lat = MULT_LAT; end
            4'd10: begin nxt = {mhi, mlo} - up; lng = 1'b1; lat = MULT_LAT; end
`endif
            default: ;
        endcase
    endfunction
    task automatic exec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] nxt;
        bit lng;
        int lat;
        predict(o, x, y, nxt, lng, lat);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        if (lng) begin
            check("busy_accept", 64'(busy), 64'd1);
            check("hilo_hold", {hi, lo}, {mhi, mlo});
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                check("busy_run", 64'(busy), 64'd1);
            end
            @(negedge clk);
        end
        {mhi, mlo} = nxt;
        check("busy_done", 64'(busy), 64'd0);
        check("hilo_result", {hi, lo}, {mhi, mlo});
    endtask
    initial begin
        logic [63:0] nxt;
        bit lng;
        int lat;
        // Reset with a MULT presented must not start anything.
        start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd7;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        start = 1'b0; op = 4'd0; reset = 1'b1;
        @(negedge clk);
        exec(4'd1, 32'hFFFFFFFE, 32'd3);
        check("mult_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFA});
        exec(4'd2, 32'hFFFFFFFE, 32'd3);
        check("multu_const", {hi, lo}, {32'h00000002, 32'hFFFFFFFA});
        exec(4'd3, 32'hFFFFFFF9, 32'd2);
        check("div_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        exec(4'd4, 32'd7, 32'd0);
        check("divz_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        exec(4'd3, 32'h80000000, 32'hFFFFFFFF);
        check("div_ovf_const", {hi, lo}, {32'h00000000, 32'h80000000});
        exec(4'd5, 32'h12345678, 32'd0);
        check("mthi_const", 64'(hi), 64'h12345678);
        // MTLO presented while a DIVU runs is ignored.
        predict(4'd4, 32'd100, 32'd7, nxt, lng, lat);
        start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd7;
        @(negedge clk);
        op = 4'd6; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        check("mtlo_busy", 64'(busy), 64'd1);
        repeat (DIV_LAT - 1) @(negedge clk);
        {mhi, mlo} = nxt;
        check("mtlo_ignored_busy", 64'(busy), 64'd0);
        check("mtlo_ignored", {hi, lo}, {32'd2, 32'd14});
        // Cancel on the third cycle of a MULT.
        start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_hilo", {hi, lo}, {mhi, mlo});
        repeat (MULT_LAT) @(negedge clk);
        check("cancel_no_late", {hi, lo}, {mhi, mlo});
        // Cancel coinciding with the commit edge.
        start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        repeat (MULT_LAT - 1) @(negedge clk);
        check("pre_commit_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_commit_busy", 64'(busy), 64'd0);
        check("cancel_commit_hilo", {hi, lo}, {mhi, mlo});
        // Cancel while idle blocks MTHI.
        start = 1'b1; op = 4'd5; a = 32'hCAFEF00D; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 4'd0; cancel = 1'b0;
        check("idle_cancel", {hi, lo}, {mhi, mlo});
        // Start held through the commit edge is ignored, taken on the next edge.
        predict(4'd2, 32'd6, 32'd7, nxt, lng, lat);
        start = 1'b1; op = 4'd2; a = 32'd6; b = 32'd7;
        @(negedge clk);
        op = 4'd5; a = 32'h0BADF00D;
        repeat (MULT_LAT) @(negedge clk);
        check("commit_edge_start", {hi, lo}, nxt);
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        check("after_commit_mthi", {hi, lo}, {32'h0BADF00D, nxt[31:0]});
        {mhi, mlo} = {32'h0BADF00D, nxt[31:0]};
        // Reset in the middle of a DIV discards it.
        start = 1'b1; op = 4'd3; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 4'd0; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        {mhi, mlo} = 64'd0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        repeat (DIV_LAT) @(negedge clk);
        check("midreset_no_commit", {hi, lo}, 64'd0);
        // Accumulate op: {hi,lo}=0x0_FFFFFFFF then MADDU 1*1.
        exec(4'd5, 32'd0, 32'd0);
        exec(4'd6, 32'hFFFFFFFF, 32'd0);
        exec(4'd8, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
        check("maddu_const", {hi, lo}, {32'h00000001, 32'h00000000});
`else
        check("maddu_reserved", {hi, lo}, {32'h00000000, 32'hFFFFFFFF});
`endif
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            exec(ro, ra, rb);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
